// File: rtl/fetch_sequencer_if.sv
// Handshake and fetch bus between the control decoder / jump LUT / instruction
// ROM side (master) and the fetch sequencer (slave).
interface fetch_sequencer_if #(
  parameter int D     = 12,
  parameter int CNT_W = 16
);
  // Control decoder and LUT side
  logic             start;
  logic             stall;
  logic             taken;
  logic             halt;
  logic [D-1:0]     lut_target;
  // Sequencer side
  logic [D-1:0]     lut_addr;
  logic             lut_jump;
  logic [D-1:0]     pc;
  logic             fetch_en;
  logic             done;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, stall, taken, halt, lut_target,
    input  lut_addr, lut_jump, pc, fetch_en, done, cycle_count, instr_count
  );

  modport slave (
    input  start, stall, taken, halt, lut_target,
    output lut_addr, lut_jump, pc, fetch_en, done, cycle_count, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter sequencer for the single-cycle core: start/done handshake,
// sequential increment, stall hold, halt detection and taken-branch redirect
// through the registered jump LUT (one bubble cycle while the LUT answers).
module fetch_sequencer #(
  parameter int D     = 12,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REDIRECT,
    S_HALT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [D-1:0]     pc_q;
  logic             done_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;
  logic [CNT_W-1:0] cycle_d;
  logic [CNT_W-1:0] instr_d;
  logic             retire;

  // Saturating counter increments and the per-cycle retire/branch decode.
  always_comb begin
    // NOTE: every signal gets a value before any condition so no latch is inferred.
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (cycle_q != CNT_MAX) cycle_d = cycle_q + CNT_W'(1);
    if (instr_q != CNT_MAX) instr_d = instr_q + CNT_W'(1);
    retire  = (state_q == S_RUN) && !bus.stall;
  end

  // fetch_en and lut_jump must follow this cycle's stall/halt/taken, so they
  // stay combinational; everything else on the bus is a register copy.
  assign bus.fetch_en    = retire;
  assign bus.lut_jump    = retire && !bus.halt && bus.taken;
  assign bus.lut_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.done        = done_q;
  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;

  // Sequencer FSM: state, pc, done flag and both counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      case (state_q)
        // Waiting for a (re)start; HALT keeps pc and counters frozen for readout.
        S_IDLE, S_HALT: begin
          if (bus.start) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            done_q  <= 1'b0;
            cycle_q <= '0;
            instr_q <= '0;
          end
        end
        // Priority: stall > halt > taken > sequential increment.
        S_RUN: begin
          cycle_q <= cycle_d;
          if (!bus.stall) begin
            instr_q <= instr_d;
            if (bus.halt) begin
              state_q <= S_HALT;
              done_q  <= 1'b1;
            end else if (bus.taken) begin
              state_q <= S_REDIRECT;
            end else begin
              pc_q <= pc_q + D'(1);
            end
          end
        end
        // LUT output is valid now; a miss returns the branch pc (self-loop).
        S_REDIRECT: begin
          cycle_q <= cycle_d;
          pc_q    <= bus.lut_target;
          state_q <= S_RUN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the sequencer
// and a behavioural jump LUT.
module tb_fetch_sequencer;
  localparam int D      = 12;
  localparam int CNT_W  = 16;
  localparam int SW     = 4;
  localparam int PC_MSK = (1 << D) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.D(D), .CNT_W(CNT_W)) bus ();
  fetch_sequencer_if #(.D(D), .CNT_W(SW))    sbus ();

  fetch_sequencer #(.D(D), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Narrow-counter copy sharing the same stimulus, used to reach saturation.
  fetch_sequencer #(.D(D), .CNT_W(SW)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus.slave)
  );

  // Behavioural jump LUT: captures addr+offset when a jump is requested.
  logic [D-1:0] lut_q = '0;
  int           lut_offset = 0;
  always @(posedge clk)
    if (bus.lut_jump) lut_q <= D'(int'(bus.lut_addr) + lut_offset);

  assign bus.lut_target  = lut_q;
  assign sbus.lut_target = lut_q;
  assign sbus.start      = bus.start;
  assign sbus.stall      = bus.stall;
  assign sbus.taken      = bus.taken;
  assign sbus.halt       = bus.halt;

  int    tests_run = 0;
  int    tests_failed = 0;
  string scen = "init";

  // Reference model: program phase flags plus unbounded counters.
  bit m_run, m_bubble, m_halted, m_done;
  int m_pc, m_target, m_cyc, m_ins;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // One clock: drive inputs at negedge, compare all outputs against the model,
  // advance the model, then return just after the active edge.
  task automatic cycle(input bit rst, input bit st, input bit sl, input bit tk, input bit hl);
    bit exp_fe, exp_lj;
    @(negedge clk);
    reset = rst; bus.start = st; bus.stall = sl; bus.taken = tk; bus.halt = hl;
    #1;
    exp_fe = m_run && !sl;
    exp_lj = m_run && !sl && !hl && tk;
    tests_run += 9;
    if (bus.pc !== D'(m_pc)) begin
      tests_failed++; $display("FAIL %s pc: got %h expected %h", scen, bus.pc, D'(m_pc));
    end
    if (bus.lut_addr !== D'(m_pc)) begin
      tests_failed++; $display("FAIL %s lut_addr: got %h expected %h", scen, bus.lut_addr, D'(m_pc));
    end
    if (bus.fetch_en !== exp_fe) begin
      tests_failed++; $display("FAIL %s fetch_en: got %b expected %b", scen, bus.fetch_en, exp_fe);
    end
    if (bus.lut_jump !== exp_lj) begin
      tests_failed++; $display("FAIL %s lut_jump: got %b expected %b", scen, bus.lut_jump, exp_lj);
    end
    if (bus.done !== m_done) begin
      tests_failed++; $display("FAIL %s done: got %b expected %b", scen, bus.done, m_done);
    end
    if (bus.cycle_count !== CNT_W'(sat(m_cyc, CNT_W))) begin
      tests_failed++; $display("FAIL %s cycle_count: got %0d expected %0d", scen, bus.cycle_count, sat(m_cyc, CNT_W));
    end
    if (bus.instr_count !== CNT_W'(sat(m_ins, CNT_W))) begin
      tests_failed++; $display("FAIL %s instr_count: got %0d expected %0d", scen, bus.instr_count, sat(m_ins, CNT_W));
    end
    if (sbus.cycle_count !== SW'(sat(m_cyc, SW))) begin
      tests_failed++; $display("FAIL %s narrow cycle_count: got %0d expected %0d", scen, sbus.cycle_count, sat(m_cyc, SW));
    end
    if (sbus.instr_count !== SW'(sat(m_ins, SW))) begin
      tests_failed++; $display("FAIL %s narrow instr_count: got %0d expected %0d", scen, sbus.instr_count, sat(m_ins, SW));
    end
    if (rst) begin
      m_run = 0; m_bubble = 0; m_halted = 0; m_done = 0; m_pc = 0; m_cyc = 0; m_ins = 0;
    end else if (m_bubble) begin
      m_cyc++; m_pc = m_target; m_bubble = 0; m_run = 1;
    end else if (m_run) begin
      m_cyc++;
      if (!sl) begin
        m_ins++;
        if (hl) begin
          m_run = 0; m_halted = 1; m_done = 1;
        end else if (tk) begin
          m_target = (m_pc + lut_offset) & PC_MSK;
          m_run = 0; m_bubble = 1;
        end else begin
          m_pc = (m_pc + 1) & PC_MSK;
        end
      end
    end else if (st) begin
      m_run = 1; m_halted = 0; m_done = 0; m_pc = 0; m_cyc = 0; m_ins = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    scen = "reset";
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    tests_run += 3;
    if (bus.pc !== 12'h000) begin
      tests_failed++; $display("FAIL reset pc: got %h expected 000", bus.pc);
    end
    if (bus.fetch_en !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL reset flags: got fe=%b done=%b expected 0 0", bus.fetch_en, bus.done);
    end
    if (bus.cycle_count !== 16'd0 || bus.instr_count !== 16'd0) begin
      tests_failed++; $display("FAIL reset counters: got %0d/%0d expected 0/0", bus.cycle_count, bus.instr_count);
    end
  endtask

  task automatic test_sequential();
    scen = "sequential";
    restart();
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    tests_run += 3;
    if (bus.pc !== 12'h005) begin
      tests_failed++; $display("FAIL sequential pc: got %h expected 005", bus.pc);
    end
    if (bus.instr_count !== 16'd5 || bus.cycle_count !== 16'd5) begin
      tests_failed++; $display("FAIL sequential counters: got %0d/%0d expected 5/5", bus.instr_count, bus.cycle_count);
    end
    if (bus.done !== 1'b0) begin
      tests_failed++; $display("FAIL sequential done: got %b expected 0", bus.done);
    end
  endtask

  task automatic test_branch();
    scen = "branch";
    restart();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    lut_offset = 20;
    cycle(0, 0, 0, 1, 0);
    tests_run += 2;
    if (bus.fetch_en !== 1'b0 || bus.pc !== 12'h004) begin
      tests_failed++; $display("FAIL branch bubble: got fe=%b pc=%h expected 0 004", bus.fetch_en, bus.pc);
    end
    if (lut_q !== 12'h018) begin
      tests_failed++; $display("FAIL branch lut capture: got %h expected 018", lut_q);
    end
    // taken/halt asserted during the bubble must be ignored
    cycle(0, 0, 0, 1, 1);
    tests_run++;
    if (bus.pc !== 12'h018 || bus.fetch_en !== 1'b1) begin
      tests_failed++; $display("FAIL branch target: got pc=%h fe=%b expected 018 1", bus.pc, bus.fetch_en);
    end
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    scen = "wrap";
    restart();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    lut_offset = -5;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    tests_run++;
    if (bus.pc !== 12'hFFD) begin
      tests_failed++; $display("FAIL wrap backward target: got %h expected FFD", bus.pc);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    tests_run++;
    if (bus.pc !== 12'h000) begin
      tests_failed++; $display("FAIL wrap increment: got %h expected 000", bus.pc);
    end
    // LUT miss: target equals the branch pc, so it re-executes itself
    lut_offset = 0;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    tests_run++;
    if (bus.pc !== 12'h000) begin
      tests_failed++; $display("FAIL wrap lut miss: got %h expected 000", bus.pc);
    end
  endtask

  task automatic test_stall();
    scen = "stall";
    restart();
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0);
    tests_run += 2;
    if (bus.pc !== 12'h007 || bus.fetch_en !== 1'b0 || bus.lut_jump !== 1'b0) begin
      tests_failed++; $display("FAIL stall hold: got pc=%h fe=%b lj=%b expected 007 0 0", bus.pc, bus.fetch_en, bus.lut_jump);
    end
    if (bus.instr_count !== 16'd7 || bus.cycle_count !== 16'd10) begin
      tests_failed++; $display("FAIL stall counters: got %0d/%0d expected 7/10", bus.instr_count, bus.cycle_count);
    end
    lut_offset = 3;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    tests_run++;
    if (bus.pc !== 12'h00A) begin
      tests_failed++; $display("FAIL stall branch after release: got %h expected 00A", bus.pc);
    end
  endtask

  task automatic test_halt();
    scen = "halt";
    restart();
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, i[0], 1, 0);
    tests_run += 2;
    if (bus.done !== 1'b1 || bus.pc !== 12'h009 || bus.fetch_en !== 1'b0) begin
      tests_failed++; $display("FAIL halt hold: got done=%b pc=%h fe=%b expected 1 009 0", bus.done, bus.pc, bus.fetch_en);
    end
    if (bus.instr_count !== 16'd10 || bus.cycle_count !== 16'd10) begin
      tests_failed++; $display("FAIL halt counters: got %0d/%0d expected 10/10", bus.instr_count, bus.cycle_count);
    end
    cycle(0, 1, 0, 0, 0);
    tests_run++;
    if (bus.pc !== 12'h000 || bus.done !== 1'b0 || bus.fetch_en !== 1'b1 ||
        bus.cycle_count !== 16'd0 || bus.instr_count !== 16'd0) begin
      tests_failed++; $display("FAIL halt restart: got pc=%h done=%b fe=%b cnt=%0d/%0d expected 000 0 1 0/0",
                               bus.pc, bus.done, bus.fetch_en, bus.cycle_count, bus.instr_count);
    end
  endtask

  task automatic test_reset_redirect();
    scen = "reset_redirect";
    restart();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    lut_offset = 100;
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    tests_run++;
    if (bus.pc !== 12'h000 || bus.done !== 1'b0 || bus.fetch_en !== 1'b0 ||
        bus.cycle_count !== 16'd0 || bus.instr_count !== 16'd0) begin
      tests_failed++; $display("FAIL reset_redirect idle: got pc=%h done=%b fe=%b cnt=%0d/%0d expected 000 0 0 0/0",
                               bus.pc, bus.done, bus.fetch_en, bus.cycle_count, bus.instr_count);
    end
  endtask

  task automatic test_random();
    scen = "random";
    restart();
    for (int i = 0; i < 3000; i++) begin
      lut_offset = int'($urandom_range(0, 255)) - 128;
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 39) == 0);
    end
  endtask

  task automatic test_saturation();
    scen = "saturation";
    restart();
    @(negedge clk);
    bus.stall = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    tests_run += 2;
    if (bus.cycle_count !== 16'hFFFF || bus.instr_count !== 16'd0) begin
      tests_failed++; $display("FAIL saturation wide: got %h/%0d expected FFFF/0", bus.cycle_count, bus.instr_count);
    end
    if (sbus.cycle_count !== 4'hF || bus.pc !== 12'h000) begin
      tests_failed++; $display("FAIL saturation narrow: got %h pc=%h expected F 000", sbus.cycle_count, bus.pc);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.taken = 1'b0; bus.halt = 1'b0;
    m_run = 0; m_bubble = 0; m_halted = 0; m_done = 0;
    m_pc = 0; m_target = 0; m_cyc = 0; m_ins = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_stall();
    test_halt();
    test_reset_redirect();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the program counter for the single-cycle core: start/done handshake with the testbench, sequential increment, stall hold, halt detection and taken-branch redirect.
- Redirect target comes from the registered jump LUT (one-cycle latency).
- Sits between the control decoder (taken/halt/stall) and the instruction ROM (pc, fetch_en). It owns the LUT's addr/jump inputs.

Parameters:
D, 12, program counter width (matches LUT and instruction ROM address width)
CNT_W, 16, width of the cycle and retired-instruction counters

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  begin program execution from pc=0; sampled in IDLE and HALT only
stall  input  1  hold pc this cycle (multi-cycle datapath op in flight)
taken  input  1  current instruction is a taken jump/branch
halt  input  1  current instruction is the halt/done opcode
lut_target  input  D  registered target returned by the jump LUT
lut_addr  output  D  address presented to the jump LUT, always equals pc
lut_jump  output  1  jump request to the LUT, combinational
pc  output  D  current fetch address
fetch_en  output  1  pc is a valid instruction to execute this cycle
done  output  1  program finished; held until next start
cycle_count  output  CNT_W  cycles spent in RUN+REDIRECT since last start, saturating
instr_count  output  CNT_W  instructions retired since last start, saturating

Behaviour:
- States: IDLE, RUN, REDIRECT, HALT. Next state, pc, done and counters are all registered.
- Reset (synchronous, takes priority over everything):
  - state=IDLE, pc=0, done=0, both counters=0.
  - Reset asserted mid-RUN or mid-REDIRECT abandons the program: IDLE the next cycle, no done pulse.
- IDLE:
  - fetch_en=0, lut_jump=0, pc held at 0.
  - start=1 -> RUN next cycle; pc=0; counters cleared; done=0.
- RUN: fetch_en = ~stall. Priority within a cycle: stall > halt > taken > increment.
  - stall=1: pc held, no retire, no LUT request; halt and taken are ignored that cycle. cycle_count still increments.
  - halt=1: retire (instr_count+1) -> HALT. pc held. done=1 from the next cycle.
  - taken=1: lut_jump=1 with lut_addr=pc. LUT captures addr+offset at this edge. Retire. -> REDIRECT.
  - Otherwise: retire; pc <= pc+1 modulo 2^D (0xFFF wraps to 0x000).
  - start is ignored in RUN.
- REDIRECT:
  - fetch_en=0 (one bubble), lut_jump=0.
  - pc <= lut_target; -> RUN unconditionally. stall, halt and taken are ignored.
  - Target arithmetic is done by the LUT (two's-complement offset, mod 2^D). A LUT miss returns addr, so the sequencer re-executes that pc. That is a legal self-loop, not an error.
- HALT:
  - done=1, fetch_en=0, pc frozen at the halt instruction address; counters frozen.
  - start=1 -> RUN next cycle with pc=0, counters cleared, done=0 on that same edge.
- Counters:
  - cycle_count increments on every RUN or REDIRECT cycle.
  - instr_count increments on each RUN cycle with stall=0.
  - Both saturate at 2^CNT_W-1 with no wrap.
- lut_addr=pc at all times. lut_jump is asserted only in RUN with taken=1, stall=0, halt=0.
- Branch latency: a taken branch costs 2 cycles (branch cycle + REDIRECT bubble). A non-branch instruction costs 1 cycle.

Test Plan:
- Reset, then start pulse, no taken/halt for 5 cycles -> pc 0,1,2,3,4 with fetch_en=1; instr_count=5, cycle_count=5, done=0.
- Branch: at pc=4, taken=1 and lut_target=0x018 (offset +20) -> lut_jump=1 with lut_addr=4; next cycle REDIRECT with fetch_en=0; following cycle pc=0x018, fetch_en=1.
- Backward branch with wrap: pc=0x002, LUT offset -5 -> pc=0xFFD. Separately, pc=0xFFF with no branch -> pc=0x000.
- Stall: stall=1 for 3 cycles at pc=7 with taken=1 also asserted -> pc stays 7, fetch_en=0, lut_jump=0, instr_count unchanged, cycle_count +3. After stall drops, the branch is taken.
- Halt at pc=9 -> done=1 next cycle and held, pc=9 frozen, counters frozen. A new start -> pc=0, done=0, counters=0, fetch_en=1.
- Reset asserted in REDIRECT -> next cycle IDLE, pc=0, done=0, counters 0, lut_target ignored. start while in RUN has no effect; cycle_count saturates at 0xFFFF with CNT_W=16.
